poolb_dp_gen: RTL
=================

POOLB_DP_GEN -- requirements
Module: poolb_dp_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bit width of one feature-map element.
REQ-002 SHALL have parameter NUM_UNITS, default 3: number of parallel channel units.
REQ-003 SHALL have parameter IFM_SIZE, default 7: input feature-map width/height in elements.
REQ-004 SHALL have parameter ARITH_TYPE, default 0: 0 = signed two's complement, 1 = unsigned.
REQ-005 SHALL have parameter POOL_MODE, default 0: 0 = max pooling, 1 = average pooling; kernel fixed 2x2, stride 2.
REQ-006 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port clear, input, 1: synchronous flush of position counters and hold registers.
REQ-009 SHALL have port in_valid, input, 1: one column of a row pair is presented.
REQ-010 SHALL have port in_ready, output, 1: block accepts the column this cycle.
REQ-011 SHALL have port data_in_A, input, NUM_UNITS*DATA_WIDTH: upper-row element per unit; unit k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port data_in_B, input, NUM_UNITS*DATA_WIDTH: lower-row element per unit, same packing.
REQ-013 SHALL have port data_out, output, NUM_UNITS*DATA_WIDTH: pooled result per unit, same packing.
REQ-014 SHALL have port out_valid, output, 1: data_out holds a result.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts data_out.
REQ-016 SHALL have port frame_last, output, 1: qualifies data_out as the final output of the frame.

Function
REQ-017 SHALL accept a column when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-018 SHALL keep column counter col (0..IFM_SIZE-1), incremented per accepted column, wrapping to 0 after IFM_SIZE-1.
REQ-019 SHALL keep row-pair counter rp (0..IFM_SIZE/2-1), incremented when col wraps, wrapping to 0 after IFM_SIZE/2-1.
REQ-020 SHALL, on an accepted column with even col, store per unit max(A,B) (mode 0) or A+B at DATA_WIDTH+2 bits (mode 1) into a hold register.
REQ-021 SHALL, on an accepted column with odd col, load data_out next edge with max(hold,A,B) (mode 0) or (hold+A+B)>>2 truncated to DATA_WIDTH (mode 1), and assert out_valid; latency 1 cycle.
REQ-022 SHALL use signed comparisons and arithmetic shift (floor) when ARITH_TYPE=0; unsigned compare and logical shift when 1.
REQ-023 SHALL, for odd IFM_SIZE, accept column IFM_SIZE-1 with no output and no hold update (floor pooling); a trailing odd row is the caller's to omit.
REQ-024 SHALL keep data_out, frame_last and out_valid stable while out_valid && !out_ready; clear out_valid on acceptance unless a new result loads the same edge.
REQ-025 SHALL set frame_last with the output produced at col = 2*(IFM_SIZE/2)-1 and rp = IFM_SIZE/2-1.
REQ-026 SHALL on clear reset col, rp and hold registers to 0; a pending output stays valid; a column presented in the same cycle as clear is not accepted (in_ready low).

Reset
REQ-027 SHALL on reset drive data_out=0, out_valid=0, frame_last=0, in_ready=1 after release, col=0, rp=0, hold=0, independent of clk.
REQ-028 SHALL on reset mid-frame discard all partial and pending results; first column after release is treated as col 0, rp 0.

Verification (NUM_UNITS=3, DATA_WIDTH=8, IFM_SIZE=4, ARITH_TYPE=0, out_ready=1 unless stated)
REQ-029 Max: unit0 col0 A=3,B=-5, col1 A=7,B=1 -> data_out unit0=7, out_valid high one cycle after col1 accept.
REQ-030 Average: unit1 4,5,6,8 -> 5; unit2 -3,-3,-3,-2 -> -3 (sum -11, floor); unsigned build 250,250,250,250 -> 250 (no overflow).
REQ-031 Backpressure: out_ready=0 with result pending, next pair presented -> in_ready=0, data_out unchanged; raise out_ready -> pair accepted, next result one cycle later.
REQ-032 Frame: stream 2 row pairs x 4 columns -> 4 outputs, frame_last only on 4th; IFM_SIZE=5 build -> column 4 produces nothing, still 4 outputs, frame_last on 4th.
REQ-033 Reset after col0 accepted -> outputs 0; next pair col0/col1 values 1,2,3,4 (max) -> 4, not mixed with pre-reset hold.
REQ-034 clear after col0 with output pending -> pending output delivered intact; following column treated as col 0.

Source files
------------

// File: rtl/poolb_dp_gen.sv
// 2x2 stride-2 pooling datapath: consumes one column of a row pair per
// accepted beat and emits one pooled element per unit every second column.
module poolb_dp_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_UNITS  = 3,
  parameter int IFM_SIZE   = 7,
  parameter int ARITH_TYPE = 0,
  parameter int POOL_MODE  = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] data_in_A,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] data_in_B,
  output logic [NUM_UNITS*DATA_WIDTH-1:0] data_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            frame_last
);

  localparam int HW    = DATA_WIDTH + 2;
  localparam int PAIRS = IFM_SIZE / 2;
  localparam int CW    = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int RW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] COL_FINAL_OUT = CW'(2 * PAIRS - 1);
  localparam logic [RW-1:0] RP_LAST       = RW'(PAIRS - 1);
  localparam bit            ODD_IFM       = (IFM_SIZE % 2) == 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_rp;
  logic [HW-1:0] r_hold [NUM_UNITS];
  logic [NUM_UNITS*DATA_WIDTH-1:0] r_dataOut;
  logic r_outValid;
  logic r_frameLast;

  logic w_accept;
  logic w_holdEn;
  logic w_outEn;
  logic [HW-1:0] w_a    [NUM_UNITS];
  logic [HW-1:0] w_b    [NUM_UNITS];
  logic [HW-1:0] w_pair [NUM_UNITS];
  logic [HW-1:0] w_quad [NUM_UNITS];
  logic [DATA_WIDTH-1:0] w_shift [NUM_UNITS];
  logic [NUM_UNITS*DATA_WIDTH-1:0] w_result;

  // Two guard bits hold the sum of four elements without overflow in either arithmetic.
  function automatic logic [HW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    if (ARITH_TYPE == 0) return {{2{v[DATA_WIDTH-1]}}, v};
    else                 return {2'b00, v};
  endfunction

  function automatic logic [HW-1:0] maxOf(input logic [HW-1:0] x, input logic [HW-1:0] y);
    logic gt;
    if (ARITH_TYPE == 0) gt = $signed(x) > $signed(y);
    else                 gt = x > y;
    return gt ? x : y;
  endfunction

  // Clear blocks acceptance so a flush never races a column into the counters.
  assign in_ready = !(r_outValid && !out_ready) && !clear;
  assign w_accept = in_valid && in_ready;
  assign w_outEn  = w_accept && r_col[0];
  assign w_holdEn = w_accept && !r_col[0] && !(ODD_IFM && (r_col == COL_LAST));

  always_comb begin
    w_result = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_a[k] = ext(data_in_A[k*DATA_WIDTH +: DATA_WIDTH]);
      w_b[k] = ext(data_in_B[k*DATA_WIDTH +: DATA_WIDTH]);
      if (POOL_MODE == 0) begin
        w_pair[k] = maxOf(w_a[k], w_b[k]);
        w_quad[k] = maxOf(r_hold[k], w_pair[k]);
      end else begin
        w_pair[k] = w_a[k] + w_b[k];
        w_quad[k] = r_hold[k] + w_pair[k];
      end
      if (ARITH_TYPE == 0) w_shift[k] = DATA_WIDTH'($signed(w_quad[k]) >>> 2);
      else                 w_shift[k] = DATA_WIDTH'(w_quad[k] >> 2);
      w_result[k*DATA_WIDTH +: DATA_WIDTH] =
        (POOL_MODE == 0) ? w_quad[k][DATA_WIDTH-1:0] : w_shift[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_rp  <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_rp  <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_rp  <= (r_rp == RP_LAST) ? '0 : r_rp + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_UNITS; k++) r_hold[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_UNITS; k++) r_hold[k] <= '0;
    end else if (w_holdEn) begin
      for (int k = 0; k < NUM_UNITS; k++) r_hold[k] <= w_pair[k];
    end
  end

  // A pending result survives clear; only the downstream handshake retires it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataOut   <= '0;
      r_outValid  <= 1'b0;
      r_frameLast <= 1'b0;
    end else if (w_outEn) begin
      r_dataOut   <= w_result;
      r_outValid  <= 1'b1;
      r_frameLast <= (r_col == COL_FINAL_OUT) && (r_rp == RP_LAST);
    end else if (r_outValid && out_ready) begin
      r_outValid  <= 1'b0;
      r_frameLast <= 1'b0;
    end
  end

  assign data_out   = r_dataOut;
  assign out_valid  = r_outValid;
  assign frame_last = r_frameLast;

endmodule
